// File: rtl/obi_slave_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : obi_slave_arbiter
//  Purpose  : Shares one OBI slave port between several OBI masters.
//             - One winner is selected per cycle.
//             - The winner is held stable until the slave grants.
//             - An in-order ID FIFO routes each rvalid/rdata back to the
//               master that issued the transaction.
//  Options  : OBI_ARB_RR_EN - round-robin arbitration when defined,
//             fixed priority (lowest index wins) otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module obi_slave_arbiter #(
    parameter int MASTERS     = 3,
    parameter int OUTSTANDING = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    // master side
    input  logic [MASTERS-1:0] m_req_i,
    output logic [MASTERS-1:0] m_gnt_o,
    output logic [MASTERS-1:0] m_rvalid_o,
    input  logic [31:0]        m_addr_i  [MASTERS],
    input  logic [MASTERS-1:0] m_we_i,
    input  logic [3:0]         m_be_i    [MASTERS],
    input  logic [31:0]        m_wdata_i [MASTERS],
    output logic [31:0]        m_rdata_o [MASTERS],
    // slave side
    output logic               s_req_o,
    input  logic               s_gnt_i,
    input  logic               s_rvalid_i,
    output logic [31:0]        s_addr_o,
    output logic               s_we_o,
    output logic [3:0]         s_be_o,
    output logic [31:0]        s_wdata_o,
    input  logic [31:0]        s_rdata_i,
    // status
    output logic               busy_o,
    output logic               err_o
);

    localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;

    localparam logic [CNT_W-1:0] FIFO_DEPTH = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(OUTSTANDING - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(MASTERS - 1);

    // response-ID FIFO state
    logic [IDX_W-1:0] fifo_mem [OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] head;

    // arbitration state
    logic             hold_valid;
    logic [IDX_W-1:0] hold_idx;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             push;
    logic             pop;
    logic             err_q;

    assign fifo_full  = (count == FIFO_DEPTH);
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

`ifdef OBI_ARB_RR_EN
    // round-robin priority pointer: the master after the last granted one
    logic [IDX_W-1:0] rr_ptr;

    // search from the pointer upward with wrap, first requester wins
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MASTERS-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        int   j;
        logic found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < MASTERS; k++) begin
            j = int'(ptr) + k;
            if (j >= MASTERS) j = j - MASTERS;
            if (!found && req[j]) begin
                rr_pick = IDX_W'(j);
                found   = 1'b1;
            end
        end
    endfunction

    // combinational round-robin choice among current requesters
    always_comb begin
        arb_idx = rr_pick(m_req_i, rr_ptr);
    end

    // advance the pointer past each granted master
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (winner == IDX_LAST) ? '0 : winner + 1'b1;
        end
    end
`else
    // fixed priority: scan downward so the lowest requesting index is kept
    always_comb begin
        arb_idx = '0;
        for (int k = MASTERS - 1; k >= 0; k--) begin
            if (m_req_i[k]) arb_idx = IDX_W'(k);
        end
    end
`endif

    assign any_req = |m_req_i;
    assign winner  = hold_valid ? hold_idx : arb_idx;
    // no bypass: a full FIFO blocks new requests even if it pops this cycle
    assign s_req_o = any_req && !fifo_full;
    assign push    = s_req_o && s_gnt_i;
    assign pop     = s_rvalid_i && !fifo_empty;
    assign busy_o  = !fifo_empty;
    assign err_o   = err_q;

    // forward the winner's transaction, zero when no request goes out
    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (s_req_o) begin
            s_addr_o  = m_addr_i[winner];
            s_we_o    = m_we_i[winner];
            s_be_o    = m_be_i[winner];
            s_wdata_o = m_wdata_i[winner];
        end
    end

    // route grant to the winner and the response to the FIFO head
    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        if (push) m_gnt_o[winner] = 1'b1;
        for (int i = 0; i < MASTERS; i++) begin
            m_rvalid_o[i] = pop && (head == IDX_W'(i));
            m_rdata_o[i]  = (pop && (head == IDX_W'(i))) ? s_rdata_i : '0;
        end
    end

    // keep the selection stable while the slave stalls the request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid <= 1'b0;
            hold_idx   <= '0;
        end else if (push) begin
            hold_valid <= 1'b0;
        end else if (hold_valid && !m_req_i[hold_idx]) begin
            // held master withdrew its request: release and re-arbitrate
            hold_valid <= 1'b0;
        end else if (s_req_o && !s_gnt_i) begin
            hold_valid <= 1'b1;
            hold_idx   <= winner;
        end
    end

    // ID storage needs no reset; entries are only read while valid
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= winner;
    end

    // FIFO pointers, occupancy and the sticky empty-response error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_rvalid_i && fifo_empty) err_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_slave_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obi_slave_arbiter
//  Purpose  : Self-checking bench for obi_slave_arbiter: a vector table,
//             directed multi-cycle sequences and random traffic compared
//             against a queue-based transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obi_slave_arbiter;

    localparam int NM  = 3;
    localparam int OUT = 2;

    logic          clk_i;
    logic          rst_ni;
    logic [NM-1:0] m_req;
    logic [NM-1:0] m_gnt;
    logic [NM-1:0] m_rvalid;
    logic [31:0]   m_addr  [NM];
    logic [NM-1:0] m_we;
    logic [3:0]    m_be    [NM];
    logic [31:0]   m_wdata [NM];
    logic [31:0]   m_rdata [NM];
    logic          s_req;
    logic          s_gnt;
    logic          s_rvalid;
    logic [31:0]   s_addr;
    logic          s_we;
    logic [3:0]    s_be;
    logic [31:0]   s_wdata;
    logic [31:0]   s_rdata;
    logic          busy;
    logic          err;

    int checks   = 0;
    int failures = 0;

    // transaction-level model state
    int mq[$];
    int hold_m;
    int rr_m;
    bit err_m;
    int last_gnt;

    obi_slave_arbiter #(.MASTERS(NM), .OUTSTANDING(OUT)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .m_req_i    (m_req),
        .m_gnt_o    (m_gnt),
        .m_rvalid_o (m_rvalid),
        .m_addr_i   (m_addr),
        .m_we_i     (m_we),
        .m_be_i     (m_be),
        .m_wdata_i  (m_wdata),
        .m_rdata_o  (m_rdata),
        .s_req_o    (s_req),
        .s_gnt_i    (s_gnt),
        .s_rvalid_i (s_rvalid),
        .s_addr_o   (s_addr),
        .s_we_o     (s_we),
        .s_be_o     (s_be),
        .s_wdata_o  (s_wdata),
        .s_rdata_i  (s_rdata),
        .busy_o     (busy),
        .err_o      (err)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
    endtask

    // distinct, recognisable payload per master
    task automatic fixed_payload();
        for (int i = 0; i < NM; i++) begin
            m_addr[i]  = 32'h1000_0000 + 32'(i) * 32'h100;
            m_we[i]    = (i == 1);
            m_be[i]    = 4'(1 << i);
            m_wdata[i] = 32'hA000_0000 + 32'(i);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        hold_m   = -1;
        rr_m     = 0;
        err_m    = 1'b0;
        last_gnt = -1;
    endtask

    // reset the DUT; returns one time unit after an active edge
    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int pick(input logic [NM-1:0] r);
`ifdef OBI_ARB_RR_EN
        for (int k = 0; k < NM; k++) if (r[(rr_m + k) % NM]) return (rr_m + k) % NM;
`else
        for (int k = 0; k < NM; k++) if (r[k]) return k;
`endif
        return 0;
    endfunction

    // predict this cycle's outputs from the arbitration rules, compare,
    // then advance the model as the clock edge will
    task automatic model_cycle();
        int           w;
        int           sz;
        bit           sreq;
        bit           grant;
        bit           pop;
        logic [NM-1:0] eg;
        logic [NM-1:0] er;
        sz    = mq.size();
        w     = (hold_m >= 0) ? hold_m : pick(m_req);
        sreq  = (m_req != '0) && (sz < OUT);
        grant = sreq && s_gnt;
        pop   = s_rvalid && (sz > 0);
        eg    = '0;
        er    = '0;
        if (grant) eg[w] = 1'b1;
        if (pop)   er[mq[0]] = 1'b1;
        chk("rnd_s_req",   32'(s_req),   32'(sreq));
        chk("rnd_s_addr",  s_addr,       sreq ? m_addr[w] : 32'h0);
        chk("rnd_s_we",    32'(s_we),    sreq ? 32'(m_we[w]) : 32'h0);
        chk("rnd_s_be",    32'(s_be),    sreq ? 32'(m_be[w]) : 32'h0);
        chk("rnd_s_wdata", s_wdata,      sreq ? m_wdata[w] : 32'h0);
        chk("rnd_m_gnt",   32'(m_gnt),   32'(eg));
        chk("rnd_m_rvalid", 32'(m_rvalid), 32'(er));
        for (int i = 0; i < NM; i++)
            chk("rnd_m_rdata", m_rdata[i], (pop && mq[0] == i) ? s_rdata : 32'h0);
        chk("rnd_busy", 32'(busy), 32'(sz != 0));
        chk("rnd_err",  32'(err),  32'(err_m));
        last_gnt = -1;
        if (grant) begin
            mq.push_back(w);
            rr_m     = (w + 1) % NM;
            hold_m   = -1;
            last_gnt = w;
        end else if (hold_m >= 0 && !m_req[hold_m]) begin
            hold_m = -1;
        end else if (sreq) begin
            hold_m = w;
        end
        if (pop) void'(mq.pop_front());
        if (s_rvalid && sz == 0) err_m = 1'b1;
    endtask

    typedef struct {
        logic [NM-1:0] req;
        logic          gnt;
        logic          rv;
        logic          exp_sreq;
        logic [NM-1:0] exp_gnt;
        logic [31:0]   exp_addr;
        logic [3:0]    exp_be;
        logic          exp_err;
    } vec_t;

    vec_t tbl[9];
    int   exp_order[6];
    int   seen;

    initial begin
        // single-cycle vectors, each applied from a fresh reset
        tbl[0] = '{3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0,          4'h0, 1'b0};
        tbl[1] = '{3'b001, 1'b1, 1'b0, 1'b1, 3'b001, 32'h1000_0000,  4'h1, 1'b0};
        tbl[2] = '{3'b010, 1'b1, 1'b0, 1'b1, 3'b010, 32'h1000_0100,  4'h2, 1'b0};
        tbl[3] = '{3'b100, 1'b1, 1'b0, 1'b1, 3'b100, 32'h1000_0200,  4'h4, 1'b0};
        tbl[4] = '{3'b110, 1'b1, 1'b0, 1'b1, 3'b010, 32'h1000_0100,  4'h2, 1'b0};
        tbl[5] = '{3'b101, 1'b0, 1'b0, 1'b1, 3'b000, 32'h1000_0000,  4'h1, 1'b0};
        tbl[6] = '{3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 32'h1000_0000,  4'h1, 1'b0};
        tbl[7] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0,          4'h0, 1'b1};
        tbl[8] = '{3'b100, 1'b1, 1'b1, 1'b1, 3'b100, 32'h1000_0200,  4'h4, 1'b1};

        rst_ni = 1'b0;
        clear_inputs();
        fixed_payload();
        model_reset();

        // reset state
        do_reset();
        #2;
        chk("reset_s_req",  32'(s_req),    32'h0);
        chk("reset_m_gnt",  32'(m_gnt),    32'h0);
        chk("reset_rvalid", 32'(m_rvalid), 32'h0);
        chk("reset_s_addr", s_addr,        32'h0);
        chk("reset_busy",   32'(busy),     32'h0);
        chk("reset_err",    32'(err),      32'h0);

        // vector table
        for (int v = 0; v < 9; v++) begin
            do_reset();
            m_req    = tbl[v].req;
            s_gnt    = tbl[v].gnt;
            s_rvalid = tbl[v].rv;
            s_rdata  = 32'h5555_AAAA;
            #2;
            chk("vec_s_req",  32'(s_req),    32'(tbl[v].exp_sreq));
            chk("vec_m_gnt",  32'(m_gnt),    32'(tbl[v].exp_gnt));
            chk("vec_s_addr", s_addr,        tbl[v].exp_addr);
            chk("vec_s_be",   32'(s_be),     32'(tbl[v].exp_be));
            chk("vec_rvalid", 32'(m_rvalid), 32'h0);
            next_cycle();
            clear_inputs();
            chk("vec_err",    32'(err),      32'(tbl[v].exp_err));
        end

        // single master read
        do_reset();
        m_req = 3'b010;
        s_gnt = 1'b1;
        #2;
        chk("read_gnt",  32'(m_gnt), 32'h2);
        chk("read_busy0", 32'(busy), 32'h0);
        next_cycle();
        clear_inputs();
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEAD_BEEF;
        #2;
        chk("read_busy1",  32'(busy),     32'h1);
        chk("read_rvalid", 32'(m_rvalid), 32'h2);
        chk("read_rdata1", m_rdata[1],    32'hDEAD_BEEF);
        chk("read_rdata0", m_rdata[0],    32'h0);
        next_cycle();
        clear_inputs();
        #2;
        chk("read_busy2", 32'(busy), 32'h0);
        chk("read_err",   32'(err),  32'h0);

        // arbitration order under continuous requests
        do_reset();
        for (int k = 0; k < 6; k++) begin
`ifdef OBI_ARB_RR_EN
            exp_order[k] = k % NM;
`else
            exp_order[k] = 0;
`endif
        end
        for (int k = 0; k < 6; k++) begin
            m_req    = 3'b111;
            s_gnt    = 1'b1;
            s_rvalid = (k != 0);
            #2;
            seen = -1;
            for (int i = 0; i < NM; i++) if (m_gnt[i]) seen = i;
            chk("order_gnt", 32'(m_gnt), 32'(1 << exp_order[k]));
            next_cycle();
        end
        clear_inputs();

        // hold stability while the slave stalls
        do_reset();
        m_req = 3'b100;
        #2;
        chk("hold_addr0", s_addr,      32'h1000_0200);
        chk("hold_gnt0",  32'(m_gnt),  32'h0);
        next_cycle();
        m_req = 3'b101;
        for (int k = 0; k < 2; k++) begin
            #2;
            chk("hold_addr", s_addr,     32'h1000_0200);
            chk("hold_gnt",  32'(m_gnt), 32'h0);
            next_cycle();
        end
        s_gnt = 1'b1;
        #2;
        chk("hold_final_gnt",  32'(m_gnt), 32'h4);
        chk("hold_final_addr", s_addr,     32'h1000_0200);
        next_cycle();
        clear_inputs();

        // full FIFO blocks requests until a response drains it
        do_reset();
        m_req = 3'b010;
        s_gnt = 1'b1;
        #2;
        chk("full_gnt1", 32'(m_gnt), 32'h2);
        next_cycle();
        m_req = 3'b100;
        #2;
        chk("full_gnt2", 32'(m_gnt), 32'h4);
        next_cycle();
        m_req = 3'b001;
        #2;
        chk("full_sreq0", 32'(s_req), 32'h0);
        chk("full_gnt3",  32'(m_gnt), 32'h0);
        chk("full_busy",  32'(busy),  32'h1);
        next_cycle();
        s_rvalid = 1'b1;
        s_rdata  = 32'h1234_5678;
        #2;
        chk("full_rvalid", 32'(m_rvalid), 32'h2);
        chk("full_rdata",  m_rdata[1],    32'h1234_5678);
        chk("full_nobypass", 32'(s_req),  32'h0);
        next_cycle();
        s_rvalid = 1'b0;
        s_gnt    = 1'b0;
        #2;
        chk("full_sreq1", 32'(s_req), 32'h1);
        chk("full_addr",  s_addr,     32'h1000_0000);
        next_cycle();
        clear_inputs();

        // response with nothing outstanding
        do_reset();
        s_rvalid = 1'b1;
        s_rdata  = 32'hFFFF_FFFF;
        #2;
        chk("oob_rvalid", 32'(m_rvalid), 32'h0);
        chk("oob_rdata",  m_rdata[0],    32'h0);
        next_cycle();
        s_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("oob_err_sticky", 32'(err), 32'h1);
            next_cycle();
        end
        do_reset();
        #2;
        chk("oob_err_cleared", 32'(err), 32'h0);

        // reset asserted with a transaction outstanding
        do_reset();
        m_req = 3'b001;
        s_gnt = 1'b1;
        next_cycle();
        clear_inputs();
        #2;
        chk("rst_busy_before", 32'(busy), 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("rst_busy_async", 32'(busy), 32'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        s_rvalid = 1'b1;
        #2;
        chk("rst_late_rvalid", 32'(m_rvalid), 32'h0);
        next_cycle();
        s_rvalid = 1'b0;
        #2;
        chk("rst_late_err", 32'(err), 32'h1);

        // random protocol-compliant traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (last_gnt >= 0) m_req[last_gnt] = 1'b0;
            for (int i = 0; i < NM; i++) begin
                if (!m_req[i] && ($urandom_range(1, 0) == 1)) begin
                    m_req[i]   = 1'b1;
                    m_addr[i]  = $urandom;
                    m_we[i]    = 1'($urandom);
                    m_be[i]    = 4'($urandom);
                    m_wdata[i] = $urandom;
                end
            end
            s_gnt    = ($urandom_range(2, 0) != 0);
            s_rvalid = (mq.size() > 0) && ($urandom_range(1, 0) == 1);
            s_rdata  = $urandom;
            #2;
            model_cycle();
            next_cycle();
        end
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obi_slave_arbiter.md
# obi_slave_arbiter

Per-slave OBI arbiter that shares one slave port between several OBI masters (JTAG host, core data, core instruction). It selects one requester per cycle, holds the selection stable until the slave grants, and records the granted master's index in an in-order response FIFO so each `rvalid`/`rdata` is routed back to the master that issued the transaction. It sits between the master side of the SoC bus and a single slave such as RAM or ROM.

## Interface
Parameters:
- `MASTERS`, 3: number of requesting masters. Index 0 is the JTAG host, 1 is core D, 2 is core I.
- `OUTSTANDING`, 2: depth of the response-ID FIFO, i.e. the maximum number of granted transactions awaiting `rvalid`. Must be a power of two, ≥1.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `m_req_i[MASTERS]`, in, 1: master request.
- `m_gnt_o[MASTERS]`, out, 1: master grant.
- `m_rvalid_o[MASTERS]`, out, 1: master response valid.
- `m_addr_i[MASTERS]`, in, 32: master address.
- `m_we_i[MASTERS]`, in, 1: master write enable.
- `m_be_i[MASTERS]`, in, 4: master byte enables.
- `m_wdata_i[MASTERS]`, in, 32: master write data.
- `m_rdata_o[MASTERS]`, out, 32: master read data.
- `s_req_o`, out, 1: slave request.
- `s_gnt_i`, in, 1: slave grant.
- `s_rvalid_i`, in, 1: slave response valid.
- `s_addr_o`, out, 32: slave address.
- `s_we_o`, out, 1: slave write enable.
- `s_be_o`, out, 4: slave byte enables.
- `s_wdata_o`, out, 32: slave write data.
- `s_rdata_i`, in, 32: slave read data.
- `busy_o`, out, 1: FIFO not empty, i.e. at least one transaction is outstanding.
- `err_o`, out, 1: sticky flag; `rvalid` received while the FIFO was empty.

## Operation
- **Winner selection (combinational)**
  - If the hold register is valid, the winner is the held index.
  - Otherwise the winner is chosen by the arbitration policy (see Configuration) among masters with `m_req_i` set.
- **Slave request**
  - `s_req_o` = (any `m_req_i` set) AND (FIFO not full).
  - `s_addr_o`, `s_we_o`, `s_be_o` and `s_wdata_o` are muxed from the winner.
  - When `s_req_o` is 0, these outputs are driven to 0.
- **Grant**
  - `s_req_o && s_gnt_i` asserts `m_gnt_o[winner]` in the same cycle and pushes the winner's index into the FIFO.
  - All other `m_gnt_o` are 0.
- **Hold register**
  - If `s_req_o && !s_gnt_i`, the winner index is latched and the hold becomes valid.
  - The hold clears on the grant cycle.
  - If the held master drops `m_req_i` (an OBI protocol violation), the hold clears and arbitration resumes on the next cycle.
- **Response**
  - `s_rvalid_i` with the FIFO not empty asserts `m_rvalid_o[head]` and `m_rdata_o[head] = s_rdata_i`, and pops the FIFO.
  - Non-selected `m_rdata_o` are 0.
- **Empty-FIFO response**: `s_rvalid_i` with the FIFO empty is dropped (no `m_rvalid_o` asserted) and sets `err_o`. `err_o` clears only on reset.
- **Simultaneous push and pop**
  - Allowed; the occupancy count is unchanged.
  - When the FIFO is full, `s_req_o` stays 0 even if a pop occurs in the same cycle (no bypass).
- **FIFO pointers**: read and write pointers are log2(`OUTSTANDING`) bits and wrap modulo `OUTSTANDING`. The count is log2(`OUTSTANDING`)+1 bits.

## Timing
- **Reset values**
  - FIFO empty, hold invalid, round-robin pointer 0.
  - `busy_o` = 0, `err_o` = 0.
  - All `m_gnt_o`, `m_rvalid_o` and `s_req_o` are 0 (absent requests).
  - All data outputs are 0.
- **Combinational paths (zero latency)**
  - request → `s_req_o`
  - `s_gnt_i` → `m_gnt_o`
  - `s_rvalid_i` → `m_rvalid_o`/`m_rdata_o`
- **Earliest response**: a transaction granted in cycle N may receive `s_rvalid_i` in cycle N+1 or later.
- **Reset asserted mid-transaction**: the FIFO is flushed and the hold is cleared. Later slave `rvalid`s set `err_o`.

## Configuration
- `OBI_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - The priority pointer is a register; after a grant to master i, the highest priority moves to (i+1) mod `MASTERS`.
  - Search order is pointer, pointer+1, … with wrap.
- `OBI_ARB_RR_EN` undefined:
  - Fixed priority; the lowest index wins (JTAG host > core D > core I).
  - No pointer register exists.

## Test plan
- **Single master read**: master 1 requests, slave grants immediately, then `s_rvalid_i` with `rdata` = 0xDEADBEEF one cycle later → `m_gnt_o[1]` pulses, `m_rvalid_o[1]` = 1, `m_rdata_o[1]` = 0xDEADBEEF, `busy_o` returns to 0.
- **Round-robin (`OBI_ARB_RR_EN`)**: all three masters request continuously and the slave always grants → grant order 0,1,2,0,1,2. Without the macro → 0,0,0….
- **Hold stability**: masters 2 and then 0 request while `s_gnt_i` = 0 for 3 cycles → `s_addr_o` stays at master 2's address every cycle until the grant, and master 0 is not granted first.
- **Full FIFO** (`OUTSTANDING` = 2): two grants with no `rvalid` → `s_req_o` = 0 while a third request is pending. One `s_rvalid_i` → the first granter gets `rvalid`, and `s_req_o` reasserts on the next cycle.
- **Out-of-band `rvalid`**: `s_rvalid_i` = 1 with the FIFO empty → no `m_rvalid_o`, and `err_o` = 1 until reset.
- **Reset mid-flight**: one outstanding transaction, then pulse `rst_ni` low → `busy_o` = 0 immediately; a later `s_rvalid_i` sets `err_o`.
